// File: rtl/csa_accum_if.sv
// Handshake bundle for csa_accum_seq: job start, operand beats and result return.
// The ovf signal exists only when CSA_ACC_OVF_EN is defined.
interface csa_accum_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             busy;
`ifdef CSA_ACC_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side.
    modport master (
        output start, num_ops, in_valid, in_a, in_b, out_ready,
`ifdef CSA_ACC_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, out_sum, busy
    );

    // Accumulator side.
    modport slave (
        input  start, num_ops, in_valid, in_a, in_b, out_ready,
`ifdef CSA_ACC_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/csa_accum_seq.sv
// Multi-operand accumulator: running total kept as carry-save (S,C) via a 4:2 compressor,
// resolved by one carry-propagate add. Optional overflow flag under CSA_ACC_OVF_EN.
module csa_accum_seq #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    csa_accum_if.slave  bus
);

`ifdef CSA_ACC_OVF_EN
    // Wide enough that 2*(2^CNT_W-1) operands of W bits never lose a carry.
    localparam int unsigned IW = W + CNT_W + 1;
`else
    localparam int unsigned IW = W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    s_q, s_d;
    logic [IW-1:0]    c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] nops_q, nops_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef CSA_ACC_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [IW-1:0]    op_a, op_b;
    logic [IW-1:0]    fa1_s;
    logic [IW-2:0]    fa1_c;
    logic [IW-1:0]    fa2_cin;
    logic [IW-2:0]    fa2_c;
    logic [IW-1:0]    cmp_s, cmp_c;
    logic [IW-1:0]    total;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    // Per-bit 4:2 compressor: two chained full adders, lateral carry into bit 0 is zero.
    always_comb begin
        op_a    = IW'(bus.in_a);
        op_b    = IW'(bus.in_b);
        fa1_s   = s_q ^ c_q ^ op_a;
        fa1_c   = (s_q[IW-2:0] & c_q[IW-2:0]) | (s_q[IW-2:0] & op_a[IW-2:0])
                | (c_q[IW-2:0] & op_a[IW-2:0]);
        fa2_cin = {fa1_c, 1'b0};
        cmp_s   = fa1_s ^ op_b ^ fa2_cin;
        fa2_c   = (fa1_s[IW-2:0] & op_b[IW-2:0]) | (fa1_s[IW-2:0] & fa2_cin[IW-2:0])
                | (op_b[IW-2:0] & fa2_cin[IW-2:0]);
        cmp_c   = {fa2_c, 1'b0};
    end

    assign total   = s_q + c_q;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign accept  = in_ready_q & bus.in_valid;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        nops_d      = nops_q;
        sum_d       = sum_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
`ifdef CSA_ACC_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    nops_d = bus.num_ops;
                    s_d    = '0;
                    c_d    = '0;
                    cnt_d  = '0;
`ifdef CSA_ACC_OVF_EN
                    ovf_d  = 1'b0;
`endif
                    if (bus.num_ops == '0) begin
                        state_d = ST_RESOLVE;
                    end else begin
                        state_d    = ST_ACCUM;
                        in_ready_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    s_d   = cmp_s;
                    c_d   = cmp_c;
                    cnt_d = cnt_inc;
                    if (cnt_inc == nops_q) begin
                        state_d    = ST_RESOLVE;
                        in_ready_d = 1'b0;
                    end
                end
            end
            ST_RESOLVE: begin
                sum_d       = total[W-1:0];
`ifdef CSA_ACC_OVF_EN
                ovf_d       = |total[IW-1:W];
`endif
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            nops_q      <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CSA_ACC_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            nops_q      <= nops_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef CSA_ACC_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.busy      = busy_q;
`ifdef CSA_ACC_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_accum_seq.sv
// Scoreboard bench for csa_accum_seq: driver pushes the arithmetic total of each job,
// an independent monitor pops and compares on every output handshake.
module tb_csa_accum_seq;
    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csa_accum_if #(.W(W), .CNT_W(CNT_W)) bus ();

    csa_accum_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int results  = 0;
    int jobs     = 0;

    logic [W-1:0] exp_q[$];
    bit           exp_ovf_q[$];
    logic [W-1:0] ja[256];
    logic [W-1:0] jb[256];
    bit           rdy_rand  = 1'b1;
    bit           rdy_force = 1'b0;
    bit           vpat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // out_ready: random, or a value forced by the directed tests.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: result compare on handshake, stability check while stalled.
    bit           stalled = 1'b0;
    logic [W-1:0] held;
    always @(negedge clk) begin
        logic [W-1:0] e;
        bit           eo;
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (bus.out_valid) begin
            if (stalled) chk("sum_stable", longint'(bus.out_sum), longint'(held));
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    chk("out_sum", longint'(bus.out_sum), longint'(e));
`ifdef CSA_ACC_OVF_EN
                    chk("ovf", longint'(bus.ovf), longint'(eo));
`endif
                    results++;
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = bus.out_sum;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (bus.busy !== 1'b0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) chk("idle_timeout", 1, 0);
    endtask

    // gap_mode: 0 back-to-back, 1 random gaps, 2 fixed 1-0-0-1-1-0-1 pattern.
    task automatic do_job(input int n, input int gap_mode);
        longint tot = 0;
        int     k   = 0;
        int     t   = 0;
        int     p   = 0;
        logic   rdy;
        wait_idle();
        for (int i = 0; i < n; i++) tot += longint'(ja[i]) + longint'(jb[i]);
        exp_q.push_back(W'(tot));
        exp_ovf_q.push_back(tot >= (longint'(1) << W));
        jobs++;
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        bus.num_ops  = CNT_W'(n);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.num_ops = CNT_W'($urandom);
        while (k < n && t < 5000) begin
            case (gap_mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = ($urandom_range(0, 3) != 0);
                default: bus.in_valid = vpat[p % 7];
            endcase
            p++;
            bus.in_a = ja[k];
            bus.in_b = jb[k];
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (bus.in_valid && rdy) k++;
            t++;
        end
        if (t >= 5000) chk("beat_timeout", 1, 0);
        // Junk on the operand bus must be ignored once in_ready drops.
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        @(negedge clk);
        chk("lat_edge1_out_valid", longint'(bus.out_valid), 0);
        chk("lat_edge1_in_ready", longint'(bus.in_ready), 0);
        @(negedge clk);
        chk("lat_edge2_out_valid", longint'(bus.out_valid), 1);
        chk("lat_edge2_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.num_ops  = '0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_out_sum", longint'(bus.out_sum), 0);
`ifdef CSA_ACC_OVF_EN
        chk("rst_ovf", longint'(bus.ovf), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three back-to-back beats.
        ja[0] = 8'd1; jb[0] = 8'd2;
        ja[1] = 8'd3; jb[1] = 8'd4;
        ja[2] = 8'd5; jb[2] = 8'd6;
        do_job(3, 0);

        // Wraparound / overflow boundary.
        ja[0] = 8'hFF; jb[0] = 8'hFF;
        ja[1] = 8'hFF; jb[1] = 8'hFF;
        do_job(2, 0);
        ja[0] = 8'h7F; jb[0] = 8'h01;
        do_job(1, 0);

        // Zero-length job.
        do_job(0, 0);

        // Valid gaps, then a stalled consumer with start pulses that must be ignored.
        wait_idle();
        rdy_rand  = 1'b0;
        rdy_force = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ja[i] = W'($urandom_range(1, 255));
            jb[i] = W'($urandom_range(1, 255));
        end
        do_job(4, 2);
        bus.num_ops = CNT_W'(3);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i % 2 == 1);
            @(negedge clk);
            chk("stall_busy", longint'(bus.busy), 1);
            chk("stall_out_valid", longint'(bus.out_valid), 1);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rdy_rand  = 1'b1;
        @(negedge clk);
        chk("post_hs_busy", longint'(bus.busy), 0);
        chk("post_hs_out_valid", longint'(bus.out_valid), 0);
        chk("post_hs_in_ready", longint'(bus.in_ready), 0);

        // Reset in the middle of a job.
        @(posedge clk);
        #1;
        wait_idle();
        bus.start   = 1'b1;
        bus.num_ops = CNT_W'(5);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = W'($urandom);
            bus.in_b     = W'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_in_ready", longint'(bus.in_ready), 0);
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_out_sum", longint'(bus.out_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ja[0] = 8'd10; jb[0] = 8'd20;
        do_job(1, 0);

        // Longest job, then random traffic.
        for (int i = 0; i < 255; i++) begin
            ja[i] = W'($urandom);
            jb[i] = W'($urandom);
        end
        do_job(255, 1);
        for (int j = 0; j < 1000; j++) begin
            n = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 15));
            for (int i = 0; i < n; i++) begin
                ja[i] = W'($urandom);
                jb[i] = W'($urandom);
            end
            do_job(n, 1);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("results_count", longint'(results), longint'(jobs));
        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
